// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the instruction-cache set RAM controller.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_DEPTH_DEFAULT = 64;
  localparam int unsigned ADDR_WIDHT_DEFAULT   = 6;
  localparam int unsigned SET_WIDHT_DEFAULT    = 256;
  localparam int unsigned N_WAYS_DEFAULT       = 4;

  typedef enum logic {
    SWEEP,
    IDLE
  } ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_ram_ctrl.sv
// Fixed-priority sequencer for the shared set RAM port: zero-fill sweep, refill write, lookup read.
module sargantana_icache_ram_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned ICACHE_DEPTH = ICACHE_DEPTH_DEFAULT,
  parameter int unsigned SET_WIDHT    = SET_WIDHT_DEFAULT,
  parameter int unsigned ADDR_WIDHT   = ADDR_WIDHT_DEFAULT,
  parameter int unsigned N_WAYS       = N_WAYS_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lookup_req_i,
  input  logic [ADDR_WIDHT-1:0] lookup_addr_i,
  output logic                  lookup_ready_o,
  output logic                  lookup_valid_o,
  input  logic                  refill_req_i,
  input  logic [N_WAYS-1:0]     refill_way_i,
  input  logic [ADDR_WIDHT-1:0] refill_addr_i,
  input  logic [SET_WIDHT-1:0]  refill_data_i,
  output logic                  refill_ack_o,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic [N_WAYS-1:0]     ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDHT-1:0] ram_addr_o,
  output logic [SET_WIDHT-1:0]  ram_data_o
);

  localparam logic [ADDR_WIDHT-1:0] LAST_INDEX = ADDR_WIDHT'(ICACHE_DEPTH - 1);

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDHT-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                  lookup_valid_q;
  logic                  flush_busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= SWEEP;
      sweep_cnt_q    <= '0;
      lookup_valid_q <= 1'b0;
      flush_busy_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      sweep_cnt_q    <= sweep_cnt_d;
      // RAM data_o appears one cycle after the read is granted.
      lookup_valid_q <= lookup_req_i & lookup_ready_o;
      flush_busy_q   <= (state_d == SWEEP);
    end
  end

  always_comb begin
    state_d        = state_q;
    sweep_cnt_d    = sweep_cnt_q;
    ram_req_o      = '0;
    ram_we_o       = 1'b0;
    ram_addr_o     = '0;
    ram_data_o     = '0;
    lookup_ready_o = 1'b0;
    refill_ack_o   = 1'b0;

    case (state_q)
      SWEEP: begin
        ram_req_o  = '1;
        ram_we_o   = 1'b1;
        ram_addr_o = sweep_cnt_q;
        if (sweep_cnt_q == LAST_INDEX) begin
          sweep_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
        end else if (refill_req_i) begin
          ram_req_o    = refill_way_i;
          ram_we_o     = 1'b1;
          ram_addr_o   = refill_addr_i;
          ram_data_o   = refill_data_i;
          refill_ack_o = 1'b1;
        end else if (lookup_req_i) begin
          ram_req_o      = '1;
          ram_addr_o     = lookup_addr_i;
          lookup_ready_o = 1'b1;
        end
      end

      default: state_d = SWEEP;
    endcase
  end

  assign lookup_valid_o = lookup_valid_q;
  assign flush_busy_o   = flush_busy_q;

endmodule

// File: tb/tb_sargantana_icache_ram_ctrl.sv
// Directed and random stimulus against a cycle-level reference model with behavioural set RAMs.
module tb_sargantana_icache_ram_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int W     = 256;
  localparam int NW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          lookup_ready;
  logic          lookup_valid;
  logic          refill_req;
  logic [NW-1:0] refill_way;
  logic [AW-1:0] refill_addr;
  logic [W-1:0]  refill_data;
  logic          refill_ack;
  logic          flush;
  logic          flush_busy;
  logic [NW-1:0] ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_data;

  always #5 clk = ~clk;

  sargantana_icache_ram_ctrl #(
    .ICACHE_DEPTH(DEPTH),
    .SET_WIDHT   (W),
    .ADDR_WIDHT  (AW),
    .N_WAYS      (NW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .lookup_req_i  (lookup_req),
    .lookup_addr_i (lookup_addr),
    .lookup_ready_o(lookup_ready),
    .lookup_valid_o(lookup_valid),
    .refill_req_i  (refill_req),
    .refill_way_i  (refill_way),
    .refill_addr_i (refill_addr),
    .refill_data_i (refill_data),
    .refill_ack_o  (refill_ack),
    .flush_i       (flush),
    .flush_busy_o  (flush_busy),
    .ram_req_o     (ram_req),
    .ram_we_o      (ram_we),
    .ram_addr_o    (ram_addr),
    .ram_data_o    (ram_data)
  );

  // Real single-port, synchronous-read set RAMs driven by the controller.
  logic [W-1:0] mem  [NW][DEPTH];
  logic [W-1:0] dout [NW];

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (ram_req[w]) begin
        if (ram_we) mem[w][ram_addr] <= ram_data;
        else        dout[w] <= mem[w][ram_addr];
      end
    end
  end

  // Reference model state
  int           sweep_left;
  bit           exp_valid;
  logic [W-1:0] exp_line [NW];
  logic [W-1:0] gold [NW][DEPTH];
  int           vectors;
  int           miscompares;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_req  = 1'b0;
    lookup_addr = '0;
    refill_req  = 1'b0;
    refill_way  = '0;
    refill_addr = '0;
    refill_data = '0;
    flush       = 1'b0;
  endtask

  // Apply reset asynchronously, check immediate effect, release just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    sweep_left = DEPTH;
    exp_valid  = 1'b0;
    chk("rst_busy",  W'(flush_busy),   W'(1'b1));
    chk("rst_valid", W'(lookup_valid), W'(1'b0));
    chk("rst_addr",  W'(ram_addr),     W'(0));
    chk("rst_ready", W'(lookup_ready), W'(1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic [NW-1:0] e_req;
    logic          e_we, e_rdy, e_ack, e_busy, grant;
    logic [AW-1:0] e_addr;
    logic [W-1:0]  e_data;
    logic [W-1:0]  cap [NW];
    bit            check_payload;

    @(negedge clk);
    e_req = '0; e_we = 1'b0; e_rdy = 1'b0; e_ack = 1'b0;
    e_addr = '0; e_data = '0; check_payload = 1'b1;
    e_busy = (sweep_left > 0);
    if (sweep_left > 0) begin
      e_req  = '1;
      e_we   = 1'b1;
      e_addr = AW'(DEPTH - sweep_left);
    end else if (flush) begin
      check_payload = 1'b0;
    end else if (refill_req) begin
      e_req  = refill_way;
      e_we   = 1'b1;
      e_addr = refill_addr;
      e_data = refill_data;
      e_ack  = 1'b1;
    end else if (lookup_req) begin
      e_req  = '1;
      e_addr = lookup_addr;
      e_rdy  = 1'b1;
    end

    chk("ram_req",  W'(ram_req),      W'(e_req));
    chk("ram_we",   W'(ram_we),       W'(e_we));
    chk("ready",    W'(lookup_ready), W'(e_rdy));
    chk("ack",      W'(refill_ack),   W'(e_ack));
    chk("busy",     W'(flush_busy),   W'(e_busy));
    chk("valid",    W'(lookup_valid), W'(exp_valid));
    if (check_payload) begin
      chk("ram_addr", W'(ram_addr), W'(e_addr));
      chk("ram_data", ram_data, e_data);
    end
    if (exp_valid) begin
      for (int w = 0; w < NW; w++) chk($sformatf("rdata_w%0d", w), dout[w], exp_line[w]);
    end

    grant = e_rdy;
    for (int w = 0; w < NW; w++) cap[w] = gold[w][lookup_addr];

    @(posedge clk);
    if (e_we) begin
      for (int w = 0; w < NW; w++) if (e_req[w]) gold[w][e_addr] = e_data;
    end
    if (sweep_left > 0)  sweep_left--;
    else if (flush)      sweep_left = DEPTH;
    exp_valid = grant;
    if (grant) for (int w = 0; w < NW; w++) exp_line[w] = cap[w];
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int w = 0; w < NW; w++) begin
      exp_line[w] = '0;
      for (int i = 0; i < DEPTH; i++) gold[w][i] = '0;
    end
    idle_inputs();

    // Power-on sweep, then first idle cycle
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) step();

    // Back-to-back lookups 5,6,7
    for (int a = 5; a <= 7; a++) begin
      lookup_req  = 1'b1;
      lookup_addr = AW'(a);
      step();
    end
    idle_inputs();
    step();
    step();

    // Refill beats a simultaneous lookup; lookup follows
    lookup_req  = 1'b1;
    lookup_addr = AW'(9);
    refill_req  = 1'b1;
    refill_way  = 4'b0100;
    refill_addr = AW'(9);
    refill_data = {8{32'hDEADBEEF}};
    step();
    refill_req = 1'b0;
    step();
    idle_inputs();
    step();

    // Flush beats refill; refill held through the sweep
    flush       = 1'b1;
    refill_req  = 1'b1;
    refill_way  = 4'b1010;
    refill_addr = AW'(17);
    refill_data = {8{32'h12345678}};
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    while (sweep_left > 0) step();
    step();
    idle_inputs();
    step();

    // Reset in the middle of a sweep
    flush = 1'b1;
    step();
    flush = 1'b0;
    while (sweep_left > DEPTH - 30) step();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) step();

    // Refill then read back through the RAMs
    refill_req  = 1'b1;
    refill_way  = 4'b0001;
    refill_addr = AW'(3);
    refill_data = {32{8'hA5}};
    step();
    idle_inputs();
    lookup_req  = 1'b1;
    lookup_addr = AW'(3);
    step();
    idle_inputs();
    step();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle_inputs();
        do_reset();
      end
      flush       = ($urandom_range(0, 59) == 0);
      refill_req  = ($urandom_range(0, 2) == 0);
      refill_way  = NW'($urandom);
      refill_addr = AW'($urandom);
      refill_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      lookup_req  = $urandom_range(0, 1) == 1;
      lookup_addr = AW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
